// File: rtl/sseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
// Segment values here are active-high; polarity is applied only at the output pins.
package sseg_pkg;

  localparam logic [7:0] SEG_OFF = 8'h00;

  // gfedcba patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic       dp;
    logic [3:0] value;
  } digit_t;

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-high gfedcba segment decode.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[value];

endmodule

// File: rtl/sseg_mux_n.sv
// N-digit multiplexed seven-segment driver: digit register file, hex decode,
// blanking, leading-zero suppression and a dead time at the start of every slot.
module sseg_mux_n
  import sseg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_BITS   = 18,
  parameter int DEAD_CYCLES    = 16,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              wr_en,
  input  logic [((N_DIGITS > 2) ? $clog2(N_DIGITS) : 1)-1:0] wr_addr,
  input  logic [3:0]                                        wr_data,
  input  logic                                              wr_dp,
  input  logic [N_DIGITS-1:0]                               blank,
  input  logic                                              lz_en,
  output logic [N_DIGITS-1:0]                               an,
  output logic [7:0]                                        sseg
);

  localparam int IDX_W = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;
  localparam logic [N_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0] SSEG_OFF_PIN = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

  logic [REFRESH_BITS-1:0] tmr_reg;
  logic [IDX_W-1:0]        idx_reg;
  digit_t                  entry_reg [N_DIGITS];
  logic [N_DIGITS-1:0]     an_reg, an_next;
  logic [7:0]              sseg_reg, sseg_next;

  logic [N_DIGITS-1:0]     nonzero;
  digit_t                  cur_entry;
  logic [6:0]              cur_seg;
  logic                    dead;
  logic                    suppress;
  logic [N_DIGITS-1:0]     an_int;
  logic [7:0]              seg_int;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_reg <= '0;
      idx_reg <= '0;
    end else begin
      tmr_reg <= tmr_reg + 1'b1;
      if (&tmr_reg) begin
        idx_reg <= (idx_reg == IDX_W'(N_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
      end
    end
  end

  // Addresses beyond N_DIGITS-1 never match any entry, so they are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_DIGITS; i++) begin
      if (reset) begin
        entry_reg[i] <= '0;
      end else if (wr_en && (wr_addr == IDX_W'(i))) begin
        entry_reg[i] <= '{dp: wr_dp, value: wr_data};
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_nz
      assign nonzero[gi] = |entry_reg[gi].value;
    end
  endgenerate

  assign cur_entry = entry_reg[idx_reg];

  hex_to_sseg u_dec (
    .value (cur_entry.value),
    .seg   (cur_seg)
  );

  always_comb begin
    dead     = tmr_reg < REFRESH_BITS'(DEAD_CYCLES);
    // Shifting the nonzero flags down by idx leaves only digits at or above idx.
    suppress = lz_en && (idx_reg != '0) && !(|(nonzero >> idx_reg));
    an_int   = '0;
    seg_int  = SEG_OFF;
    if (!dead) begin
      an_int = N_DIGITS'(1) << idx_reg;
      if (!blank[idx_reg] && !suppress) begin
        seg_int = {cur_entry.dp, cur_seg};
      end
    end
    an_next   = (AN_ACTIVE_LOW != 0) ? ~an_int : an_int;
    sseg_next = (SEG_ACTIVE_LOW != 0) ? ~seg_int : seg_int;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_reg   <= AN_OFF;
      sseg_reg <= SSEG_OFF_PIN;
    end else begin
      an_reg   <= an_next;
      sseg_reg <= sseg_next;
    end
  end

  assign an   = an_reg;
  assign sseg = sseg_reg;

endmodule

// File: tb/tb_sseg_mux_n.sv
// Self-checking bench for sseg_mux_n (4 digits, 8-clock slots, 2-clock dead time,
// active-low pins) against a slot-arithmetic reference model.
module tb_sseg_mux_n;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic [3:0] blank;
  logic       lz_en;
  logic [3:0] an;
  logic [7:0] sseg;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: t = clocks since reset released
  int         t;
  logic [3:0] m_val [4];
  logic       m_dp  [4];
  logic [3:0] exp_an;
  logic [7:0] exp_sseg;
  int         exp_idx;
  logic       exp_active;

  sseg_mux_n #(
    .N_DIGITS       (4),
    .REFRESH_BITS   (3),
    .DEAD_CYCLES    (2),
    .AN_ACTIVE_LOW  (1),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_dp   (wr_dp),
    .blank   (blank),
    .lz_en   (lz_en),
    .an      (an),
    .sseg    (sseg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic model_out();
    int         tm;
    logic       zero_hi;
    logic [7:0] seg;
    tm         = t % 8;
    exp_idx    = (t / 8) % 4;
    exp_active = (tm >= 2);
    if (!exp_active) begin
      exp_an   = 4'hF;
      exp_sseg = 8'hFF;
    end else begin
      exp_an  = ~(4'b0001 << exp_idx);
      zero_hi = 1'b1;
      for (int k = exp_idx; k < 4; k++) if (m_val[k] != 4'd0) zero_hi = 1'b0;
      if (blank[exp_idx] || (lz_en && exp_idx > 0 && zero_hi)) seg = 8'h00;
      else seg = {m_dp[exp_idx], hex7(m_val[exp_idx])};
      exp_sseg = ~seg;
    end
  endtask

  // Predict the outputs of the coming edge, take the edge, then advance the model.
  task automatic tick();
    if (reset) begin
      exp_an     = 4'hF;
      exp_sseg   = 8'hFF;
      exp_active = 1'b0;
      exp_idx    = 0;
    end else begin
      model_out();
    end
    @(posedge clk);
    #1;
    if (reset) begin
      t = 0;
      for (int k = 0; k < 4; k++) begin m_val[k] = 4'd0; m_dp[k] = 1'b0; end
    end else begin
      if (wr_en) begin
        m_val[wr_addr] = wr_data;
        m_dp[wr_addr]  = wr_dp;
      end
      t++;
    end
  endtask

  task automatic write_digit(input logic [1:0] a, input logic [3:0] d, input logic p);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = p;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int found;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (an !== 4'hF || sseg !== 8'hFF) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d an=%h sseg=%h expected an=F sseg=FF", i, an, sseg);
      end
    end
    reset = 1'b0;
    found = 0;
    for (int k = 1; k <= 20 && found == 0; k++) begin
      tick();
      if (an === 4'b1110) found = k;
    end
    n_tests++;
    if (found != 3) begin
      n_fail++;
      $display("FAIL reset_first_anode clocks=%0d expected 3", found);
    end
  endtask

  task automatic test_scan();
    logic [7:0] lit [4];
    lit[0] = 8'hF9; lit[1] = 8'hA4; lit[2] = 8'h30; lit[3] = 8'h88;
    write_digit(2'd0, 4'h1, 1'b0);
    write_digit(2'd1, 4'h2, 1'b0);
    write_digit(2'd2, 4'h3, 1'b1);
    write_digit(2'd3, 4'hA, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick();
      n_tests++;
      if (an !== exp_an || sseg !== exp_sseg) begin
        n_fail++;
        $display("FAIL scan_model t=%0d an=%h sseg=%h expected an=%h sseg=%h", t, an, sseg, exp_an, exp_sseg);
      end
      if (exp_active) begin
        n_tests++;
        if (sseg !== lit[exp_idx] || an !== ~(4'b0001 << exp_idx)) begin
          n_fail++;
          $display("FAIL scan_digit idx=%0d an=%h sseg=%h expected sseg=%h", exp_idx, an, sseg, lit[exp_idx]);
        end
      end
    end
  endtask

  task automatic test_leading_zeros();
    logic [7:0] lit;
    write_digit(2'd3, 4'h0, 1'b0);
    write_digit(2'd2, 4'h0, 1'b0);
    write_digit(2'd1, 4'h5, 1'b0);
    write_digit(2'd0, 4'h0, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      lz_en = (pass == 0);
      for (int i = 0; i < 34; i++) begin
        tick();
        n_tests++;
        if (an !== exp_an || sseg !== exp_sseg) begin
          n_fail++;
          $display("FAIL lz_model lz=%0d t=%0d an=%h sseg=%h expected an=%h sseg=%h", lz_en, t, an, sseg, exp_an, exp_sseg);
        end
        if (exp_active) begin
          if (exp_idx >= 2) lit = lz_en ? 8'hFF : 8'hC0;
          else if (exp_idx == 1) lit = 8'h92;
          else lit = 8'hC0;
          n_tests++;
          if (sseg !== lit || an !== ~(4'b0001 << exp_idx)) begin
            n_fail++;
            $display("FAIL lz_digit lz=%0d idx=%0d an=%h sseg=%h expected sseg=%h", lz_en, exp_idx, an, sseg, lit);
          end
        end
      end
    end
    lz_en = 1'b0;
  endtask

  task automatic test_blank();
    blank = 4'b0010;
    for (int i = 0; i < 34; i++) begin
      tick();
      n_tests++;
      if (an !== exp_an || sseg !== exp_sseg) begin
        n_fail++;
        $display("FAIL blank_model t=%0d an=%h sseg=%h expected an=%h sseg=%h", t, an, sseg, exp_an, exp_sseg);
      end
      if (exp_active && exp_idx == 1) begin
        n_tests++;
        if (an !== 4'hD || sseg !== 8'hFF) begin
          n_fail++;
          $display("FAIL blank_digit1 an=%h sseg=%h expected an=D sseg=FF", an, sseg);
        end
      end
    end
    blank = 4'b0000;
  endtask

  task automatic test_live_write();
    int         ix;
    int         guard;
    logic [3:0] d;
    logic       p;
    guard = 0;
    while ((t % 8) != 3 && guard < 64) begin tick(); guard++; end
    n_tests++;
    if (guard >= 64) begin
      n_fail++;
      $display("FAIL live_wait timeout t=%0d", t);
    end
    ix = (t / 8) % 4;
    wr_en = 1'b1; wr_addr = 2'(ix); wr_data = 4'h8; wr_dp = 1'b0;
    tick();
    wr_en = 1'b0;
    n_tests++;
    if (an !== exp_an || sseg !== exp_sseg) begin
      n_fail++;
      $display("FAIL live_first_edge an=%h sseg=%h expected an=%h sseg=%h", an, sseg, exp_an, exp_sseg);
    end
    tick();
    n_tests++;
    if (sseg !== 8'h80 || an !== ~(4'b0001 << ix)) begin
      n_fail++;
      $display("FAIL live_write idx=%0d an=%h sseg=%h expected sseg=80", ix, an, sseg);
    end

    guard = 0;
    while ((t % 8) != 7 && guard < 64) begin tick(); guard++; end
    d = 4'($urandom_range(1, 15));
    p = 1'($urandom_range(0, 1));
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = d; wr_dp = p;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (exp_active && exp_idx == 3) begin
        n_tests++;
        if (sseg !== ~{p, hex7(d)}) begin
          n_fail++;
          $display("FAIL wrap_write sseg=%h expected %h", sseg, ~{p, hex7(d)});
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    guard = 0;
    while (!(((t / 8) % 4) == 2 && (t % 8) == 4) && guard < 64) begin tick(); guard++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if (an !== 4'hF || sseg !== 8'hFF) begin
      n_fail++;
      $display("FAIL mid_reset an=%h sseg=%h expected an=F sseg=FF", an, sseg);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      n_tests++;
      if (an !== exp_an || (exp_active && sseg !== 8'hC0)) begin
        n_fail++;
        $display("FAIL mid_reset_cleared t=%0d an=%h sseg=%h expected an=%h sseg=C0", t, an, sseg, exp_an);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 99) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      wr_dp   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) blank = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom_range(0, 1));
      tick();
      n_tests++;
      if (an !== exp_an || sseg !== exp_sseg) begin
        n_fail++;
        $display("FAIL random cyc=%0d an=%h sseg=%h expected an=%h sseg=%h", i, an, sseg, exp_an, exp_sseg);
      end
    end
    reset = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'h0; wr_dp = 1'b0;
    blank = 4'b0000; lz_en = 1'b0; t = 0;
    for (int k = 0; k < 4; k++) begin m_val[k] = 4'd0; m_dp[k] = 1'b0; end
    test_reset();
    test_scan();
    test_leading_zeros();
    test_blank();
    test_live_write();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
